fb_fill_engine: RTL and testbench
=================================

FB_FILL_ENGINE -- requirements
Module: fb_fill_engine

Interface
REQ-001 Parameters: FB_W, default 160, framebuffer width in pixels.
REQ-002 Parameters: FB_H, default 120, framebuffer height in pixels.
REQ-003 Parameters: REG_BASE, default 32'h0000_F000, byte address of the 4-word register block.
REQ-004 Parameters: FB_BASE, default 32'h0000_0000, byte address of framebuffer pixel (0,0); 1 byte per pixel, row-major.
REQ-005 Ports: sysclk, input, 1, sole clock, all logic on rising edge.
REQ-006 Ports: reset, input, 1, synchronous, active-high.
REQ-007 Ports: mem_write, input, 1, CPU store strobe.
REQ-008 Ports: alu_result, input, 32, CPU byte address for both load and store.
REQ-009 Ports: write_data, input, 32, CPU store data.
REQ-010 Ports: reg_rdata, output, 32, register read data, combinational from alu_result.
REQ-011 Ports: reg_sel, output, 1, high when alu_result hits REG_BASE..REG_BASE+15.
REQ-012 Ports: fb_we, output, 1, framebuffer write request.
REQ-013 Ports: fb_addr, output, 32, framebuffer byte address.
REQ-014 Ports: fb_wdata, output, 8, pixel value.
REQ-015 Ports: fb_gnt, input, 1, arbiter accepts the write this cycle; the CPU store has priority.
REQ-016 Ports: irq, output, 1, one-cycle pulse on completion.

Function
REQ-017 Register map (word offsets): +0 RECT0 {y0[31:16],x0[15:0]}; +4 RECT1 {y1,x1}, inclusive corners; +8 COLOR [7:0]; +C CTRL, write bit0=start; read {29'b0,err,done,busy}.
REQ-018 RECT0, RECT1 and COLOR are written when mem_write && reg_sel && !busy; writes while busy are ignored; reads always return the current values.
REQ-019 States: IDLE, FILL.
REQ-020 IDLE->FILL on a CTRL write with bit0=1 and valid geometry (x0<=x1<FB_W, y0<=y1<FB_H); same edge: done<=0, err<=0, cursor<=(x0,y0).
REQ-021 Start with invalid geometry: stay IDLE, no fb_we, err<=1, done<=1, irq pulses next cycle.
REQ-022 Start while busy: ignored.
REQ-023 In FILL: fb_we=1; fb_addr=FB_BASE+cy*FB_W+cx; fb_wdata=COLOR.
REQ-024 In FILL, fb_addr and fb_wdata are held stable until fb_gnt=1.
REQ-025 Cursor advances only on fb_we&&fb_gnt, in raster order: cx++ while cx<x1, else cx=x0 and cy++.
REQ-026 Acceptance of (x1,y1): FILL->IDLE on the next edge; done<=1; irq=1 for exactly that one cycle.
REQ-027 Throughput: with fb_gnt tied high, one pixel per cycle; a rectangle of N pixels keeps fb_we high for exactly N cycles.
REQ-028 First fb_we is in the cycle after the start store.
REQ-029 Single-pixel rectangle (x0=x1, y0=y1) is legal and produces exactly one write.
REQ-030 Address arithmetic is 32-bit unsigned; cy*FB_W uses a constant multiplier.
REQ-031 busy=(state==FILL).
REQ-032 done and err are sticky until the next start.

Reset
REQ-033 On reset: state=IDLE; RECT0=RECT1=0; COLOR=0; busy=done=err=0; fb_we=0; irq=0; fb_addr=FB_BASE; fb_wdata=0.
REQ-034 Reset asserted mid-FILL aborts on that edge: no further fb_we, done stays 0, no irq.

Verification
REQ-035 RECT0=(2,1), RECT1=(3,2), COLOR=8'h01, start, fb_gnt=1 -> 4 writes, to addrs 162,163,322,323 in order; irq one cycle after the last write; CTRL reads 3'b010.
REQ-036 Same rectangle, fb_gnt low for 3 cycles on the second pixel -> addr 163 held for 4 cycles; exactly 4 writes total.
REQ-037 RECT1 x1=160 (>=FB_W), start -> no fb_we; CTRL reads 3'b110; irq pulses once.
REQ-038 Store to COLOR=8'hFF while busy -> ignored: the remaining pixels are written with the old value and the COLOR readback is unchanged.
REQ-039 Full screen (0,0)-(159,119), fb_gnt=1 -> exactly 19200 writes; last addr 19199; cy wraps correctly at each row.
REQ-040 reset pulsed after the 5th write of a 100-pixel fill -> fb_we=0 next cycle; all registers are 0; no irq.

Source files
------------

// File: rtl/fb_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fb_fill_engine
//  Description : Memory-mapped rectangle fill engine. The CPU programs two
//                corners and a colour, then starts a raster-order fill that
//                issues one framebuffer byte write per granted cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fb_fill_engine #(
  parameter int          FB_W     = 160,
  parameter int          FB_H     = 120,
  parameter logic [31:0] REG_BASE = 32'h0000_F000,
  parameter logic [31:0] FB_BASE  = 32'h0000_0000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  output logic [31:0] reg_rdata,
  output logic        reg_sel,
  output logic        fb_we,
  output logic [31:0] fb_addr,
  output logic [7:0]  fb_wdata,
  input  logic        fb_gnt,
  output logic        irq
);

  localparam logic [31:0] c_fb_w = 32'(FB_W);
  localparam logic [31:0] c_fb_h = 32'(FB_H);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_rect0;
  logic [31:0] r_rect1;
  logic [7:0]  r_color;
  logic        r_done;
  logic        r_err;
  logic        r_irq;
  logic [15:0] r_cx;
  logic [15:0] r_cy;
  logic [31:0] r_addr;
  logic [7:0]  r_wdata;

  logic [31:0] w_off;
  logic [1:0]  w_idx;
  logic        w_busy;
  logic        w_wr;
  logic        w_start;
  logic        w_geom_ok;
  logic        w_accept;
  logic        w_row_end;
  logic        w_last;
  logic [15:0] w_x0, w_y0, w_x1, w_y1;
  logic [31:0] w_start_addr;
  logic [31:0] w_row_step;

  // Register block decode: offset from the block base, hit when within 16 bytes.
  assign w_off   = alu_result - REG_BASE;
  assign reg_sel = (w_off < 32'd16);
  assign w_idx   = w_off[3:2];

  assign w_busy  = (r_state == ST_FILL);
  assign w_wr    = mem_write && reg_sel && !w_busy;
  assign w_start = w_wr && (w_idx == 2'd3) && write_data[0];

  assign w_x0 = r_rect0[15:0];
  assign w_y0 = r_rect0[31:16];
  assign w_x1 = r_rect1[15:0];
  assign w_y1 = r_rect1[31:16];

  assign w_geom_ok = (w_x0 <= w_x1) && ({16'b0, w_x1} < c_fb_w) &&
                     (w_y0 <= w_y1) && ({16'b0, w_y1} < c_fb_h);

  // Corner registers cannot change while filling, so these stay stable.
  assign w_accept  = w_busy && fb_gnt;
  assign w_row_end = (r_cx == w_x1);
  assign w_last    = w_accept && w_row_end && (r_cy == w_y1);

  // Starting address uses the constant-width multiply once per fill; the
  // running address is then stepped incrementally.
  assign w_start_addr = FB_BASE + ({16'b0, w_y0} * c_fb_w) + {16'b0, w_x0};
  assign w_row_step   = c_fb_w - {16'b0, (w_x1 - w_x0)};

  assign fb_we    = w_busy;
  assign fb_addr  = r_addr;
  assign fb_wdata = r_wdata;
  assign irq      = r_irq;

  // Geometry and colour registers, writable only while idle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_rect0 <= 32'd0;
      r_rect1 <= 32'd0;
      r_color <= 8'd0;
    end else if (w_wr) begin
      case (w_idx)
        2'd0:    r_rect0 <= write_data;
        2'd1:    r_rect1 <= write_data;
        2'd2:    r_color <= write_data[7:0];
        default: ;
      endcase
    end
  end

  // Fill sequencer: start validation, raster cursor, address and completion.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_irq   <= 1'b0;
      r_cx    <= 16'd0;
      r_cy    <= 16'd0;
      r_addr  <= FB_BASE;
      r_wdata <= 8'd0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            if (w_geom_ok) begin
              r_state <= ST_FILL;
              r_cx    <= w_x0;
              r_cy    <= w_y0;
              r_addr  <= w_start_addr;
              r_wdata <= r_color;
            end else begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
              r_irq  <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
              r_irq   <= 1'b1;
            end else if (w_row_end) begin
              r_cx   <= w_x0;
              r_cy   <= r_cy + 16'd1;
              r_addr <= r_addr + w_row_step;
            end else begin
              r_cx   <= r_cx + 16'd1;
              r_addr <= r_addr + 32'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Register readback, combinational from the CPU address.
  always_comb begin
    reg_rdata = 32'd0;
    if (reg_sel) begin
      case (w_idx)
        2'd0:    reg_rdata = r_rect0;
        2'd1:    reg_rdata = r_rect1;
        2'd2:    reg_rdata = {24'd0, r_color};
        default: reg_rdata = {29'd0, r_err, r_done, w_busy};
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_fill_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fb_fill_engine
//  Description : Self-checking bench for fb_fill_engine. Expected pixel
//                addresses come from nested row/column loops over the
//                rectangle; a table of vectors plus random rectangles drive it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fb_fill_engine;

  localparam int          FB_W     = 160;
  localparam int          FB_H     = 120;
  localparam logic [31:0] REG_BASE = 32'h0000_F000;
  localparam logic [31:0] FB_BASE  = 32'h0000_0000;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b1;
  logic        mem_write = 1'b0;
  logic [31:0] alu_result = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [31:0] reg_rdata;
  logic        reg_sel;
  logic        fb_we;
  logic [31:0] fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_gnt = 1'b1;
  logic        irq;

  int passed = 0;
  int total  = 0;

  fb_fill_engine #(
    .FB_W(FB_W), .FB_H(FB_H), .REG_BASE(REG_BASE), .FB_BASE(FB_BASE)
  ) dut (
    .sysclk(sysclk), .reset(reset), .mem_write(mem_write),
    .alu_result(alu_result), .write_data(write_data),
    .reg_rdata(reg_rdata), .reg_sel(reg_sel), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_wdata(fb_wdata), .fb_gnt(fb_gnt), .irq(irq)
  );

  always #5 sysclk = ~sysclk;

  // mode: 0 = grant tied high, 1 = random grant, 2 = grant low 3 cycles on pixel 2
  typedef struct {
    logic [15:0] x0, y0, x1, y1;
    logic [7:0]  color;
    int          mode;
    bit          midcolor;
    int          exp_n;
    logic [2:0]  exp_ctrl;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge sysclk) #1;
    mem_write = 1'b1; alu_result = a; write_data = d;
    @(posedge sysclk) #1;
    mem_write = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    alu_result = a;
    #1;
    d = reg_rdata;
  endtask

  function automatic bit geom_valid(input vec_t v);
    return (v.x0 <= v.x1) && (int'(v.x1) < FB_W) && (v.y0 <= v.y1) && (int'(v.y1) < FB_H);
  endfunction

  task automatic run_rect(input vec_t v, input string tag);
    logic [31:0] q[$];
    logic [31:0] last_addr, d;
    int idx, we_cycles, irqs, irq_cyc, last_cyc, hold_cnt, low_cnt, cyc, bound;
    idx = 0; we_cycles = 0; irqs = 0; irq_cyc = -100; last_cyc = -1;
    hold_cnt = 0; low_cnt = 0; cyc = 0; last_addr = 32'hDEAD_BEEF;
    wr(REG_BASE + 0, {v.y0, v.x0});
    wr(REG_BASE + 4, {v.y1, v.x1});
    wr(REG_BASE + 8, {24'd0, v.color});
    if (geom_valid(v))
      for (int y = int'(v.y0); y <= int'(v.y1); y++)
        for (int x = int'(v.x0); x <= int'(v.x1); x++)
          q.push_back(FB_BASE + 32'(y * FB_W + x));
    mem_write = 1'b1; alu_result = REG_BASE + 12; write_data = 32'd1;
    bound = 4 * v.exp_n + 40;
    while (cyc < bound) begin
      @(posedge sysclk) #1;
      mem_write  = v.midcolor && (cyc == 2);
      alu_result = REG_BASE + 8;
      write_data = 32'hFF;
      case (v.mode)
        1: fb_gnt = ($urandom_range(0, 3) != 0);
        2: if (idx == 1 && low_cnt < 3) begin fb_gnt = 1'b0; low_cnt++; end
           else fb_gnt = 1'b1;
        default: fb_gnt = 1'b1;
      endcase
      @(negedge sysclk);
      if (fb_we) begin
        we_cycles++;
        if (idx < q.size()) begin
          check({tag, " fb_addr"}, fb_addr, q[idx]);
          check({tag, " fb_wdata"}, {24'd0, fb_wdata}, {24'd0, v.color});
          if (idx == 1) hold_cnt++;
          if (fb_gnt) begin last_addr = fb_addr; idx++; last_cyc = cyc; end
        end else begin
          check({tag, " spurious_we"}, {31'd0, fb_we}, 32'd0);
        end
      end
      if (irq) begin irqs++; irq_cyc = cyc; end
      cyc++;
      if (idx >= q.size() && cyc > last_cyc + 4) break;
    end
    mem_write = 1'b0;
    fb_gnt = 1'b1;
    check({tag, " writes"}, idx, v.exp_n);
    check({tag, " irq_count"}, irqs, 1);
    check({tag, " irq_cycle"}, irq_cyc, last_cyc + 1);
    if (v.mode == 0) check({tag, " we_cycles"}, we_cycles, v.exp_n);
    if (v.mode == 2) check({tag, " hold_cycles"}, hold_cnt, 4);
    if (v.exp_n > 0)
      check({tag, " last_addr"}, last_addr, FB_BASE + 32'(int'(v.y1) * FB_W + int'(v.x1)));
    rd(REG_BASE + 12, d);
    check({tag, " ctrl"}, d, {29'd0, v.exp_ctrl});
    rd(REG_BASE + 8, d);
    check({tag, " color_rb"}, d, {24'd0, v.color});
  endtask

  vec_t tbl[9];

  initial begin
    logic [31:0] d;
    vec_t rv;
    int n, cyc, we_cnt, irq_cnt;

    tbl[0] = '{16'd2, 16'd1, 16'd3,   16'd2,   8'h01, 0, 1'b0, 4,     3'b010};
    tbl[1] = '{16'd2, 16'd1, 16'd3,   16'd2,   8'h01, 2, 1'b0, 4,     3'b010};
    tbl[2] = '{16'd2, 16'd1, 16'd160, 16'd2,   8'h01, 0, 1'b0, 0,     3'b110};
    tbl[3] = '{16'd5, 16'd5, 16'd5,   16'd5,   8'h5A, 0, 1'b0, 1,     3'b010};
    tbl[4] = '{16'd3, 16'd0, 16'd2,   16'd0,   8'h11, 0, 1'b0, 0,     3'b110};
    tbl[5] = '{16'd0, 16'd119, 16'd0, 16'd119, 8'h77, 1, 1'b0, 1,     3'b010};
    tbl[6] = '{16'd0, 16'd0, 16'd0,   16'd120, 8'h22, 0, 1'b0, 0,     3'b110};
    tbl[7] = '{16'd10, 16'd3, 16'd14, 16'd6,   8'hAA, 1, 1'b1, 20,    3'b010};
    tbl[8] = '{16'd0, 16'd0, 16'd159, 16'd119, 8'hC3, 0, 1'b0, 19200, 3'b010};

    repeat (3) @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    check("rst fb_we", {31'd0, fb_we}, 32'd0);
    check("rst irq", {31'd0, irq}, 32'd0);
    check("rst fb_addr", fb_addr, FB_BASE);
    check("rst fb_wdata", {24'd0, fb_wdata}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(REG_BASE + 32'(4 * i), d);
      check("rst reg", d, 32'd0);
    end
    alu_result = REG_BASE + 15; #1; check("reg_sel top", {31'd0, reg_sel}, 32'd1);
    alu_result = REG_BASE + 16; #1; check("reg_sel above", {31'd0, reg_sel}, 32'd0);
    alu_result = REG_BASE - 1;  #1; check("reg_sel below", {31'd0, reg_sel}, 32'd0);

    for (int i = 0; i < 9; i++) run_rect(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 6; i++) begin
      rv.x0 = 16'($urandom_range(0, 150));
      rv.x1 = rv.x0 + 16'($urandom_range(0, 9));
      rv.y0 = 16'($urandom_range(0, 110));
      rv.y1 = rv.y0 + 16'($urandom_range(0, 9));
      rv.color = 8'($urandom_range(0, 255));
      rv.mode = 1;
      rv.midcolor = 1'($urandom_range(0, 1));
      rv.exp_n = (int'(rv.x1) - int'(rv.x0) + 1) * (int'(rv.y1) - int'(rv.y0) + 1);
      rv.exp_ctrl = 3'b010;
      run_rect(rv, $sformatf("rand%0d", i));
    end

    // Reset mid-fill of a 10x10 rectangle after the 5th accepted write.
    wr(REG_BASE + 0, 32'h0000_0000);
    wr(REG_BASE + 4, {16'd9, 16'd9});
    wr(REG_BASE + 8, 32'h33);
    mem_write = 1'b1; alu_result = REG_BASE + 12; write_data = 32'd1;
    n = 0; cyc = 0; we_cnt = 0; irq_cnt = 0;
    while (n < 5 && cyc < 50) begin
      @(posedge sysclk) #1;
      mem_write = 1'b0; fb_gnt = 1'b1;
      @(negedge sysclk);
      if (fb_we && fb_gnt) n++;
      if (irq) irq_cnt++;
      cyc++;
    end
    check("rstfill pre_writes", n, 5);
    @(posedge sysclk) #1 reset = 1'b1;
    @(posedge sysclk) #1 reset = 1'b0;
    @(negedge sysclk);
    check("rstfill fb_we", {31'd0, fb_we}, 32'd0);
    if (irq) irq_cnt++;
    repeat (5) begin
      @(negedge sysclk);
      if (fb_we) we_cnt++;
      if (irq) irq_cnt++;
    end
    check("rstfill we_after", we_cnt, 0);
    check("rstfill irq", irq_cnt, 0);
    check("rstfill fb_addr", fb_addr, FB_BASE);
    check("rstfill fb_wdata", {24'd0, fb_wdata}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      rd(REG_BASE + 32'(4 * i), d);
      check("rstfill reg", d, 32'd0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
